// File: rtl/shift_issue_stage.sv
// ID/EX pipeline register for R-type shift instructions: decodes sll/srl/sra/sllv/srlv/srav,
// forwards rs/rt from EX/MEM and MEM/WB, and registers the operand triple for the EX barrel shifter.
module shift_issue_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [31:0]      id_instr,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic             ex_stall,
    input  logic             flush,
    input  logic             exmem_wen,
    input  logic [4:0]       exmem_rd,
    input  logic [WIDTH-1:0] exmem_data,
    input  logic             memwb_wen,
    input  logic [4:0]       memwb_rd,
    input  logic [WIDTH-1:0] memwb_data,
    output logic             id_ready,
    output logic             ex_valid,
    output logic             ex_is_shift,
    output logic [WIDTH-1:0] ex_amt,
    output logic [WIDTH-1:0] ex_opnd,
    output logic [1:0]       ex_ctrl,
    output logic [4:0]       ex_rd,
    output logic [CNT_W-1:0] shift_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Register 0 is hard-wired, so it is never forwarded; EX/MEM is the younger result and wins.
    function automatic logic [WIDTH-1:0] fwd_sel(
        input logic [4:0]       idx,
        input logic [WIDTH-1:0] rf,
        input logic             ew,
        input logic [4:0]       erd,
        input logic [WIDTH-1:0] ed,
        input logic             mw,
        input logic [4:0]       mrd,
        input logic [WIDTH-1:0] md
    );
        if (ew && erd != 5'd0 && erd == idx)
            return ed;
        else if (mw && mrd != 5'd0 && mrd == idx)
            return md;
        else
            return rf;
    endfunction

    logic [WIDTH-1:0] rs_fwd_p0;
    logic [WIDTH-1:0] rt_fwd_p0;
    logic             dec_shift_p0;
    logic [4:0]       dec_amt_p0;
    logic [1:0]       dec_ctrl_p0;
    logic             unused_rs_hi;

    assign id_ready = ~ex_stall;

    assign rs_fwd_p0 = fwd_sel(id_instr[25:21], id_rs_data, exmem_wen, exmem_rd, exmem_data,
                               memwb_wen, memwb_rd, memwb_data);
    assign rt_fwd_p0 = fwd_sel(id_instr[20:16], id_rt_data, exmem_wen, exmem_rd, exmem_data,
                               memwb_wen, memwb_rd, memwb_data);

    // Only the low five bits of a variable amount reach the shifter.
    assign unused_rs_hi = ^rs_fwd_p0[WIDTH-1:5];

    always_comb begin
        dec_shift_p0 = 1'b0;
        dec_amt_p0   = 5'd0;
        dec_ctrl_p0  = 2'b00;
        if (id_instr[31:26] == 6'd0) begin
            case (id_instr[5:0])
                6'b000000: begin dec_shift_p0 = 1'b1; dec_amt_p0 = id_instr[10:6]; dec_ctrl_p0 = 2'b00; end
                6'b000010: begin dec_shift_p0 = 1'b1; dec_amt_p0 = id_instr[10:6]; dec_ctrl_p0 = 2'b01; end
                6'b000011: begin dec_shift_p0 = 1'b1; dec_amt_p0 = id_instr[10:6]; dec_ctrl_p0 = 2'b11; end
                6'b000100: begin dec_shift_p0 = 1'b1; dec_amt_p0 = rs_fwd_p0[4:0]; dec_ctrl_p0 = 2'b00; end
                6'b000110: begin dec_shift_p0 = 1'b1; dec_amt_p0 = rs_fwd_p0[4:0]; dec_ctrl_p0 = 2'b01; end
                6'b000111: begin dec_shift_p0 = 1'b1; dec_amt_p0 = rs_fwd_p0[4:0]; dec_ctrl_p0 = 2'b11; end
                default:   ;
            endcase
        end
    end

    // ID -> EX boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_is_shift <= 1'b0;
            ex_amt      <= '0;
            ex_opnd     <= '0;
            ex_ctrl     <= 2'b00;
            ex_rd       <= 5'd0;
            shift_cnt   <= '0;
        end else if (flush) begin
            ex_valid    <= 1'b0;
            ex_is_shift <= 1'b0;
        end else if (!ex_stall) begin
            ex_valid <= id_valid;
            if (id_valid) begin
                ex_is_shift <= dec_shift_p0;
                ex_amt      <= dec_shift_p0 ? {{(WIDTH-5){1'b0}}, dec_amt_p0} : '0;
                ex_opnd     <= dec_shift_p0 ? rt_fwd_p0 : '0;
                ex_ctrl     <= dec_shift_p0 ? dec_ctrl_p0 : 2'b00;
                ex_rd       <= dec_shift_p0 ? id_instr[15:11] : 5'd0;
                if (dec_shift_p0)
                    shift_cnt <= sat_inc(shift_cnt);
            end else begin
                ex_is_shift <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_issue_stage.sv
// Randomised scoreboard bench for shift_issue_stage; a narrow-counter twin exercises saturation.
module tb_shift_issue_stage;

    logic        clk = 1'b0;
    logic        reset, id_valid, ex_stall, flush, exmem_wen, memwb_wen;
    logic [31:0] id_instr, id_rs_data, id_rt_data, exmem_data, memwb_data;
    logic [4:0]  exmem_rd, memwb_rd;

    logic        id_ready, ex_valid, ex_is_shift;
    logic [31:0] ex_amt, ex_opnd;
    logic [1:0]  ex_ctrl;
    logic [4:0]  ex_rd;
    logic [15:0] shift_cnt;

    logic        s_id_ready, s_ex_valid, s_ex_is_shift;
    logic [31:0] s_ex_amt, s_ex_opnd;
    logic [1:0]  s_ex_ctrl;
    logic [4:0]  s_ex_rd;
    logic [2:0]  s_shift_cnt;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit          ev, sh;
        logic [31:0] amt, opnd;
        logic [1:0]  ctrl;
        logic [4:0]  rd;
        int          cnt, cnt_s;
    } exp_t;

    exp_t q[$];
    exp_t m;

    always #5 clk = ~clk;

    shift_issue_stage #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .ex_stall(ex_stall), .flush(flush),
        .exmem_wen(exmem_wen), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .memwb_wen(memwb_wen), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .id_ready(id_ready), .ex_valid(ex_valid), .ex_is_shift(ex_is_shift), .ex_amt(ex_amt),
        .ex_opnd(ex_opnd), .ex_ctrl(ex_ctrl), .ex_rd(ex_rd), .shift_cnt(shift_cnt)
    );

    shift_issue_stage #(.WIDTH(32), .CNT_W(3)) dut_small (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .ex_stall(ex_stall), .flush(flush),
        .exmem_wen(exmem_wen), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .memwb_wen(memwb_wen), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .id_ready(s_id_ready), .ex_valid(s_ex_valid), .ex_is_shift(s_ex_is_shift),
        .ex_amt(s_ex_amt), .ex_opnd(s_ex_opnd), .ex_ctrl(s_ex_ctrl), .ex_rd(s_ex_rd),
        .shift_cnt(s_shift_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                          input int sh, input int funct);
        logic [31:0] w;
        w = {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(funct)};
        return w;
    endfunction

    // Reference: register value as seen in ID after applying the bypass network.
    function automatic logic [31:0] ref_fwd(input int idx, input logic [31:0] rf);
        if (exmem_wen && exmem_rd != 0 && int'(exmem_rd) == idx) return exmem_data;
        if (memwb_wen && memwb_rd != 0 && int'(memwb_rd) == idx) return memwb_data;
        return rf;
    endfunction

    task automatic apply(input bit r, input bit v, input logic [31:0] instr,
                         input logic [31:0] rsd, input logic [31:0] rtd,
                         input bit st, input bit fl,
                         input bit ew, input int erd, input logic [31:0] ed,
                         input bit mw, input int mrd, input logic [31:0] md);
        int   funct, rs_i, rt_i;
        bit   is_sh, var_amt;
        logic [31:0] rs_v, rt_v;
        @(negedge clk);
        reset = r; id_valid = v; id_instr = instr; id_rs_data = rsd; id_rt_data = rtd;
        ex_stall = st; flush = fl; exmem_wen = ew; exmem_rd = 5'(erd); exmem_data = ed;
        memwb_wen = mw; memwb_rd = 5'(mrd); memwb_data = md;
        #1;
        chk("id_ready", {31'd0, id_ready}, {31'd0, ~st});

        funct = int'(instr[5:0]);
        rs_i  = int'(instr[25:21]);
        rt_i  = int'(instr[20:16]);
        rs_v  = ref_fwd(rs_i, rsd);
        rt_v  = ref_fwd(rt_i, rtd);
        is_sh = (instr[31:26] == 0) && (funct inside {0, 2, 3, 4, 6, 7});
        var_amt = funct >= 4;

        if (r) begin
            m = '{default: 0};
        end else if (fl) begin
            m.ev = 0; m.sh = 0;
        end else if (!st) begin
            m.ev = v;
            if (!v) m.sh = 0;
            else if (!is_sh) begin
                m.sh = 0; m.amt = 0; m.opnd = 0; m.ctrl = 0; m.rd = 0;
            end else begin
                m.sh   = 1;
                m.amt  = var_amt ? (rs_v % 32) : 32'(instr[10:6]);
                m.opnd = rt_v;
                m.ctrl = (funct % 4 == 0) ? 2'b00 : (funct % 4 == 2) ? 2'b01 : 2'b11;
                m.rd   = instr[15:11];
                m.cnt   = (m.cnt   < 65535) ? m.cnt + 1   : 65535;
                m.cnt_s = (m.cnt_s < 7)     ? m.cnt_s + 1 : 7;
            end
        end
        q.push_back(m);
    endtask

    // Monitor: one registered output set per clock, compared against the oldest expectation.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("ex_valid",    {31'd0, ex_valid},    {31'd0, e.ev});
            chk("ex_is_shift", {31'd0, ex_is_shift}, {31'd0, e.sh});
            chk("ex_amt",      ex_amt,               e.amt);
            chk("ex_opnd",     ex_opnd,              e.opnd);
            chk("ex_ctrl",     {30'd0, ex_ctrl},     {30'd0, e.ctrl});
            chk("ex_rd",       {27'd0, ex_rd},       {27'd0, e.rd});
            chk("shift_cnt",   {16'd0, shift_cnt},   32'(e.cnt));
            chk("shift_cnt_sat3", {29'd0, s_shift_cnt}, 32'(e.cnt_s));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int funcs[7] = '{0, 2, 3, 4, 6, 7, 32};
        logic [31:0] w;
        // Reset state
        repeat (2) apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // T1 sll rd=8 rt=9 shamt=4
        apply(0, 1, rtype(0, 9, 8, 4, 0), 0, 32'hF, 0, 0, 0, 0, 0, 0, 0, 0);
        // T2 srav with EX/MEM bypass of rs
        apply(0, 1, rtype(5, 6, 10, 0, 7), 32'h1, 32'h1234, 0, 0, 1, 5, 32'h23, 0, 0, 0);
        // T3 priority of EX/MEM over MEM/WB; then register 0 never forwarded
        apply(0, 1, rtype(0, 7, 3, 1, 0), 0, 32'h77, 0, 0, 1, 7, 32'hAAAA0000, 1, 7, 32'h5555);
        apply(0, 1, rtype(0, 0, 3, 1, 0), 0, 32'h66, 0, 0, 1, 0, 32'hAAAA0000, 1, 0, 32'h5555);
        // T4 srl, three stalls with changing ID, then flush during stall
        apply(0, 1, rtype(0, 4, 2, 9, 2), 0, 32'h80000000, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            apply(0, 1, rtype(i, i + 1, i + 2, i + 3, 3), $urandom, $urandom, 1, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 1, rtype(1, 2, 3, 4, 0), 0, 5, 1, 1, 0, 0, 0, 0, 0, 0);
        // T5 add is captured as non-shift, then reset mid-stream
        apply(0, 1, rtype(1, 2, 3, 4, 32), 9, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(1, 1, rtype(0, 2, 3, 4, 0), 9, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        // T6 saturation: ten back-to-back shifts push the narrow twin past its ceiling
        for (int i = 0; i < 10; i++)
            apply(0, 1, rtype(0, 1, 1, i, 0), 0, i, 0, 0, 0, 0, 0, 0, 0, 0);
        // Randomised traffic with small register indices to provoke bypass hits
        for (int i = 0; i < 3000; i++) begin
            w = rtype($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 31),
                      $urandom_range(0, 31), funcs[$urandom_range(0, 6)]);
            if ($urandom_range(0, 9) == 0) w[31:26] = 6'($urandom_range(1, 63));
            if ($urandom_range(0, 9) == 0) w[5:0]   = 6'($urandom);
            apply($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 8, w, $urandom, $urandom,
                  $urandom_range(0, 9) < 2, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom);
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_drain", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
